// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480 timing, RGB444 field layout and the line-fetch state encoding.
package vga_pkg;
   localparam int H_ACT   = 640;
   localparam int H_FRONT = 16;
   localparam int H_SYNC  = 96;
   localparam int H_BACK  = 48;
   localparam int H_TOTAL = H_ACT + H_FRONT + H_SYNC + H_BACK;

   localparam int V_ACT   = 480;
   localparam int V_FRONT = 10;
   localparam int V_SYNC  = 2;
   localparam int V_BACK  = 33;
   localparam int V_TOTAL = V_ACT + V_FRONT + V_SYNC + V_BACK;

   localparam int RGB_W = 12;
   localparam int R_HI  = 11;
   localparam int R_LO  = 8;
   localparam int G_HI  = 7;
   localparam int G_LO  = 4;
   localparam int B_HI  = 3;
   localparam int B_LO  = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;
endpackage

// File: rtl/line_buffer_ram.sv
// Two-bank line buffer, address {bank, index}; one write port and one read port on the same clock.
// Read data is registered: address in cycle n, data in cycle n+1. No stalls.
module line_buffer_ram #(
   parameter int DATA_W = 12,
   parameter int IDX_W  = 10,
   parameter int WORDS  = 640
) (
   input  logic              i_clk,
   input  logic              i_wr_en,
   input  logic [IDX_W:0]    i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [IDX_W:0]    i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);
   logic [DATA_W-1:0] r_mem [0:1][0:WORDS-1];
   logic [DATA_W-1:0] r_rd_data;

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr[IDX_W]][i_wr_addr[IDX_W-1:0]] <= i_wr_data;
      end
      r_rd_data <= r_mem[i_rd_addr[IDX_W]][i_rd_addr[IDX_W-1:0]];
   end

   assign o_rd_data = r_rd_data;
endmodule

// File: rtl/vga_line_prefetch.sv
// Prefetches line y+1 from SDRAM into the idle bank while line y is shown; pixel latency 1 cycle.
// Read requests hold address while iMemWaitRequest is high; a missed fetch deadline sets sticky oUnderflow.
module vga_line_prefetch #(
   parameter int H_ACT  = 640,
   parameter int V_ACT  = 480,
   parameter int ADDR_W = 22
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iTopOfScreen,
   input  logic              iRequest,
   input  logic [9:0]        iCurrent_X,
   input  logic [9:0]        iCurrent_Y,
   input  logic [ADDR_W-1:0] iFrameBase,
   output logic [ADDR_W-1:0] oMemAddress,
   output logic              oMemRead,
   input  logic              iMemWaitRequest,
   input  logic [15:0]       iMemReadData,
   input  logic              iMemReadDataValid,
   output logic [3:0]        oRed,
   output logic [3:0]        oGreen,
   output logic [3:0]        oBlue,
   output logic              oUnderflow
);
   import vga_pkg::*;

   localparam logic [9:0]        LAST_IDX    = 10'(H_ACT - 1);
   localparam logic [9:0]        LINE_WORDS  = 10'(H_ACT);
   localparam logic [9:0]        LAST_TRIG_Y = 10'(V_ACT - 1);
   localparam logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(H_ACT);

   fetch_state_t      r_state, w_next_state;
   logic [ADDR_W-1:0] r_la, r_base, r_top_base, w_start_base;
   logic [9:0]        r_issue_cnt, r_ret_cnt;
   logic              r_bank, w_start_bank;
   logic              r_pending_top, r_underflow, r_req_d;
   logic              w_idle, w_line_trig, w_start_top, w_start_line, w_accept, w_ret;
   logic [RGB_W-1:0]  w_pix;
   logic              w_unused_rdata;

   always_comb begin
      w_idle       = (r_state == IDLE);
      w_line_trig  = iRequest && (iCurrent_X == 10'd0) && (iCurrent_Y < LAST_TRIG_Y);
      w_start_top  = w_idle && (iTopOfScreen || r_pending_top);
      w_start_line = w_idle && !w_start_top && w_line_trig;
      w_accept     = (r_state == ISSUE) && !iMemWaitRequest;
      w_ret        = iMemReadDataValid && !w_idle && (r_ret_cnt != LINE_WORDS);
      w_start_base = r_la;
      w_start_bank = ~iCurrent_Y[0];
      if (w_start_top) begin
         // A fresh pulse while idle beats a deferred one.
         w_start_base = iTopOfScreen ? iFrameBase : r_top_base;
         w_start_bank = 1'b0;
      end
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (w_start_top || w_start_line) w_next_state = ISSUE;
         ISSUE:   if (w_accept && (r_issue_cnt == LAST_IDX)) w_next_state = DRAIN;
         DRAIN:   if (r_ret_cnt == LINE_WORDS) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_la          <= '0;
         r_base        <= '0;
         r_top_base    <= '0;
         r_issue_cnt   <= '0;
         r_ret_cnt     <= '0;
         r_bank        <= 1'b0;
         r_pending_top <= 1'b0;
         r_underflow   <= 1'b0;
         r_req_d       <= 1'b0;
      end else begin
         r_req_d <= iRequest;
         if (w_start_top || w_start_line) begin
            r_base      <= w_start_base;
            r_la        <= w_start_base + LINE_STRIDE;
            r_bank      <= w_start_bank;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
         end else begin
            if (w_accept) r_issue_cnt <= r_issue_cnt + 10'd1;
            if (w_ret)    r_ret_cnt   <= r_ret_cnt + 10'd1;
         end
         if (w_start_top) r_pending_top <= 1'b0;
         if (!w_idle && iTopOfScreen) begin
            r_pending_top <= 1'b1;
            r_top_base    <= iFrameBase;
         end
         if (!w_idle && (iTopOfScreen || w_line_trig)) r_underflow <= 1'b1;
      end
   end

   line_buffer_ram #(
      .DATA_W(RGB_W),
      .IDX_W (10),
      .WORDS (H_ACT)
   ) u_line_buffer_ram (
      .i_clk    (iCLK),
      .i_wr_en  (w_ret),
      .i_wr_addr({r_bank, r_ret_cnt}),
      .i_wr_data(iMemReadData[RGB_W-1:0]),
      .i_rd_addr({iCurrent_Y[0], iCurrent_X}),
      .o_rd_data(w_pix)
   );

   assign w_unused_rdata = ^iMemReadData[15:RGB_W];
   assign oMemRead       = (r_state == ISSUE);
   assign oMemAddress    = r_base + ADDR_W'(r_issue_cnt);
   assign oRed           = r_req_d ? w_pix[R_HI:R_LO] : 4'd0;
   assign oGreen         = r_req_d ? w_pix[G_HI:G_LO] : 4'd0;
   assign oBlue          = r_req_d ? w_pix[B_HI:B_LO] : 4'd0;
   assign oUnderflow     = r_underflow;
endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed bench for vga_line_prefetch with a latency/stall-configurable Avalon read model.
module tb_vga_line_prefetch;
   import vga_pkg::*;

   localparam int AW = 22;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b1;
   logic          iTopOfScreen = 1'b0;
   logic          iRequest = 1'b0;
   logic [9:0]    iCurrent_X = '0;
   logic [9:0]    iCurrent_Y = '0;
   logic [AW-1:0] iFrameBase = '0;
   logic [AW-1:0] oMemAddress;
   logic          oMemRead;
   logic          iMemWaitRequest = 1'b0;
   logic [15:0]   iMemReadData = '0;
   logic          iMemReadDataValid = 1'b0;
   logic [3:0]    oRed, oGreen, oBlue;
   logic          oUnderflow;

   vga_line_prefetch #(.H_ACT(H_ACT), .V_ACT(V_ACT), .ADDR_W(AW)) dut (
      .iCLK(iCLK), .iRST(iRST), .iTopOfScreen(iTopOfScreen), .iRequest(iRequest),
      .iCurrent_X(iCurrent_X), .iCurrent_Y(iCurrent_Y), .iFrameBase(iFrameBase),
      .oMemAddress(oMemAddress), .oMemRead(oMemRead), .iMemWaitRequest(iMemWaitRequest),
      .iMemReadData(iMemReadData), .iMemReadDataValid(iMemReadDataValid),
      .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oUnderflow(oUnderflow)
   );

   always #5 iCLK = ~iCLK;

   int n_vec = 0;
   int n_err = 0;

   // Memory model: word at address a holds {4'hA, a[11:0]}; returns in order after lat cycles.
   int            cyc = 0;
   int            lat = 3;
   bit            stall_en = 1'b0;
   int            stall_viol = 0;
   logic          prev_rd = 1'b0, prev_wait = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [AW-1:0] pend_addr[$];
   int            pend_due[$];
   logic [AW-1:0] acc_log[$];

   always @(negedge iCLK) begin
      cyc++;
      if (stall_en && prev_rd && prev_wait && (!oMemRead || oMemAddress != prev_addr))
         stall_viol++;
      iMemWaitRequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (oMemRead && !iMemWaitRequest) begin
         pend_addr.push_back(oMemAddress);
         pend_due.push_back(cyc + lat);
         acc_log.push_back(oMemAddress);
      end
      prev_rd   = oMemRead;
      prev_wait = iMemWaitRequest;
      prev_addr = oMemAddress;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         iMemReadDataValid = 1'b1;
         iMemReadData      = {4'hA, pend_addr[0][11:0]};
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         iMemReadDataValid = 1'b0;
         iMemReadData      = 16'($urandom);
      end
   end

   typedef struct {
      logic        req;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] exp_rgb;
   } pix_vec_t;

   localparam int NV = 12;
   pix_vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge iCLK);
   endtask

   task automatic pulse_top(input logic [AW-1:0] base, input logic [AW-1:0] after);
      iTopOfScreen = 1'b1;
      iFrameBase   = base;
      @(negedge iCLK);
      iTopOfScreen = 1'b0;
      iFrameBase   = after;
   endtask

   task automatic trig(input int y);
      iRequest   = 1'b1;
      iCurrent_X = 10'd0;
      iCurrent_Y = 10'(y);
      @(negedge iCLK);
      iRequest   = 1'b0;
   endtask

   task automatic wait_fetch(input string name, input int n_words, input bit drain, input int budget);
      int t = 0;
      while ((acc_log.size() < n_words || (drain && pend_addr.size() != 0)) && t < budget) begin
         @(negedge iCLK);
         t++;
      end
      check({name, " timeout"}, 32'(t >= budget), 32'd0);
      if (drain) tick(4);
   endtask

   function automatic int seq_breaks(input int from, input int n);
      int b = 0;
      for (int i = from + 1; i < from + n && i < acc_log.size(); i++)
         if (acc_log[i] != acc_log[i-1] + AW'(1)) b++;
      return b;
   endfunction

   task automatic check_fetch(input string name, input logic [AW-1:0] base);
      check({name, " count"}, 32'(acc_log.size()), 32'(H_ACT));
      if (acc_log.size() >= H_ACT) begin
         check({name, " first"}, 32'(acc_log[0]), 32'(base));
         check({name, " last"}, 32'(acc_log[H_ACT-1]), 32'(base + AW'(H_ACT - 1)));
         check({name, " order"}, 32'(seq_breaks(0, H_ACT)), 32'd0);
      end
   endtask

   task automatic run_table(input string tag);
      for (int i = 0; i < NV; i++) begin
         iRequest   = vecs[i].req;
         iCurrent_X = vecs[i].x;
         iCurrent_Y = vecs[i].y;
         @(negedge iCLK);
         check($sformatf("%s pix%0d", tag, i), 32'({oRed, oGreen, oBlue}), 32'(vecs[i].exp_rgb));
      end
      iRequest = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete, got %0d vectors, expected completion", n_vec);
      $fatal(1);
   end

   initial begin
      int sum_act, sum_exp, t;
      // pixel (x,y) = (y*640 + x) mod 4096; bank0 = line 0, bank1 = line 1
      vecs[0]  = '{1'b1, 10'd5,   10'd0, 12'h005};
      vecs[1]  = '{1'b1, 10'd639, 10'd0, 12'h27F};
      vecs[2]  = '{1'b1, 10'd1,   10'd1, 12'h281};
      vecs[3]  = '{1'b1, 10'd639, 10'd1, 12'h4FF};
      vecs[4]  = '{1'b0, 10'd5,   10'd0, 12'h000};
      vecs[5]  = '{1'b1, 10'd300, 10'd1, 12'h3AC};
      vecs[6]  = '{1'b1, 10'd100, 10'd0, 12'h064};
      vecs[7]  = '{1'b0, 10'd639, 10'd1, 12'h000};
      vecs[8]  = '{1'b1, 10'd320, 10'd0, 12'h140};
      vecs[9]  = '{1'b1, 10'd7,   10'd2, 12'h007};
      vecs[10] = '{1'b1, 10'd2,   10'd3, 12'h282};
      vecs[11] = '{1'b1, 10'd1,   10'd0, 12'h001};

      tick(3);
      check("rst oMemRead", 32'(oMemRead), 32'd0);
      check("rst oMemAddress", 32'(oMemAddress), 32'd0);
      check("rst rgb", 32'({oRed, oGreen, oBlue}), 32'd0);
      check("rst oUnderflow", 32'(oUnderflow), 32'd0);
      iRST = 1'b0;
      tick(2);

      // Line 0 fetch from top of screen
      acc_log.delete();
      pulse_top(22'h10000, 22'h3F000);
      check("top first read", 32'(oMemRead), 32'd1);
      check("top first addr", 32'(oMemAddress), 32'h10000);
      wait_fetch("line0", H_ACT, 1'b1, 4 * H_TOTAL);
      check_fetch("line0", 22'h10000);
      check("line0 idle", 32'(oMemRead), 32'd0);
      check("line0 underflow", 32'(oUnderflow), 32'd0);

      // Line 1 fetch triggered at X=0 of line 0, then display both banks
      acc_log.delete();
      trig(0);
      check("line1 first read", 32'(oMemRead), 32'd1);
      check("line1 first addr", 32'(oMemAddress), 32'h10280);
      wait_fetch("line1", H_ACT, 1'b1, 4 * H_TOTAL);
      check_fetch("line1", 22'h10280);
      run_table("frame1");

      // Random wait-states on line 2 fetch into bank 0
      acc_log.delete();
      stall_viol = 0;
      stall_en = 1'b1;
      trig(1);
      wait_fetch("stall", H_ACT, 1'b1, 8 * H_TOTAL);
      stall_en = 1'b0;
      check("stall held", 32'(stall_viol), 32'd0);
      check_fetch("stall", 22'h10500);
      sum_act = 0;
      sum_exp = 0;
      iRequest   = 1'b1;
      iCurrent_Y = 10'd2;
      for (int x = 1; x < H_ACT; x++) begin
         iCurrent_X = 10'(x);
         @(negedge iCLK);
         sum_act += int'({oRed, oGreen, oBlue});
         sum_exp += (2 * H_ACT + x) % 4096;
      end
      iRequest = 1'b0;
      check("stall checksum", 32'(sum_act), 32'(sum_exp));
      check("stall underflow", 32'(oUnderflow), 32'd0);

      // 300-cycle latency: next trigger lands in DRAIN
      lat = 300;
      acc_log.delete();
      trig(2);
      wait_fetch("slow issue", H_ACT, 1'b0, 4 * H_TOTAL);
      tick(10);
      trig(3);
      check("late trig no read", 32'(oMemRead), 32'd0);
      check("late trig underflow", 32'(oUnderflow), 32'd1);
      wait_fetch("slow drain", H_ACT, 1'b1, 4 * H_TOTAL);
      check("slow no extra reads", 32'(acc_log.size()), 32'(H_ACT));
      lat = 3;
      acc_log.delete();
      trig(4);
      check("recover read", 32'(oMemRead), 32'd1);
      check("recover addr", 32'(oMemAddress), 32'h10A00);
      wait_fetch("recover", H_ACT, 1'b1, 4 * H_TOTAL);
      check_fetch("recover", 22'h10A00);

      // Top-of-screen during line 478's fetch is deferred
      acc_log.delete();
      trig(478);
      check("l478 addr", 32'(oMemAddress), 32'h10C80);
      tick(100);
      pulse_top(22'h20000, 22'h30000);
      check("pend still reading", 32'(oMemRead), 32'd1);
      check("pend underflow", 32'(oUnderflow), 32'd1);
      wait_fetch("pend", 2 * H_ACT, 1'b1, 8 * H_TOTAL);
      check("pend count", 32'(acc_log.size()), 32'(2 * H_ACT));
      if (acc_log.size() >= 2 * H_ACT) begin
         check("l478 last", 32'(acc_log[H_ACT-1]), 32'h10EFF);
         check("pend first", 32'(acc_log[H_ACT]), 32'h20000);
         check("pend last", 32'(acc_log[2*H_ACT-1]), 32'h2027F);
         check("pend order", 32'(seq_breaks(H_ACT, H_ACT)), 32'd0);
      end

      // Reset mid-ISSUE with ~100 returns outstanding
      lat = 100;
      acc_log.delete();
      pulse_top(22'h10000, 22'h0);
      tick(200);
      iRST = 1'b1;
      tick(1);
      check("midrst oMemRead", 32'(oMemRead), 32'd0);
      check("midrst oMemAddress", 32'(oMemAddress), 32'd0);
      check("midrst oUnderflow", 32'(oUnderflow), 32'd0);
      iRST = 1'b0;
      t = 0;
      while (pend_addr.size() != 0 && t < V_TOTAL) begin
         @(negedge iCLK);
         t++;
      end
      check("stray drain timeout", 32'(t >= V_TOTAL), 32'd0);
      tick(4);
      check("stray no read", 32'(oMemRead), 32'd0);
      lat = 3;
      acc_log.delete();
      pulse_top(22'h10000, 22'h0);
      wait_fetch("rf line0", H_ACT, 1'b1, 4 * H_TOTAL);
      check_fetch("rf line0", 22'h10000);
      acc_log.delete();
      trig(0);
      wait_fetch("rf line1", H_ACT, 1'b1, 4 * H_TOTAL);
      check_fetch("rf line1", 22'h10280);
      run_table("frame2");

      // Last visible line starts no fetch; reads bank 1 index 0 (line 1 pixel 0)
      trig(479);
      check("l479 no read", 32'(oMemRead), 32'd0);
      check("l479 pixel", 32'({oRed, oGreen, oBlue}), 32'h280);
      tick(2);
      check("l479 no underflow", 32'(oUnderflow), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
